// File: rtl/priority_sel_arbiter.sv
// Six-source arbiter driving the 6:1 priority mux select. Highest index wins,
// and the selection is held until valid & out_ready. Define AGING_EN to promote starved sources.
module priority_sel_arbiter #(
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] req,
  input  logic       out_ready,
  output logic [4:0] sel,
  output logic [5:0] grant,
  output logic       valid,
  output logic [5:0] ack
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_r, state_nxt_s;
  logic [5:0] grant_r, grant_nxt_s;
  logic [4:0] sel_r, sel_nxt_s;
  logic       valid_r, valid_nxt_s;
  logic       handshake_s;
  logic [5:0] winner_s;

  // One-hot of the highest set bit; zero when nothing is set.
  function automatic logic [5:0] highest_onehot(input logic [5:0] v);
    logic [5:0] r;
    r = 6'b000000;
    for (int k = 0; k < 6; k++) begin
      if (v[k]) r = 6'b000001 << k;
    end
    return r;
  endfunction

  assign handshake_s = valid_r & out_ready;

`ifdef AGING_EN
  logic [WAIT_W-1:0] wait_r [5];
  logic [4:0]        aged_s;

  // A requesting source whose counter has saturated is aged.
  always_comb begin
    aged_s = 5'b00000;
    for (int k = 0; k < 5; k++) begin
      aged_s[k] = req[k] && (wait_r[k] == WAIT_W'(MAX_WAIT));
    end
  end

  // Highest aged source overrides the strict-priority winner.
  always_comb begin
    if (|aged_s) begin
      winner_s = highest_onehot({1'b0, aged_s});
    end else begin
      winner_s = highest_onehot(req);
    end
  end

  // Per-source lost-arbitration counters, updated only at a handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 5; k++) wait_r[k] <= '0;
    end else if (handshake_s) begin
      for (int k = 0; k < 5; k++) begin
        if (grant_r[k]) begin
          wait_r[k] <= '0;
        end else if (req[k] && (wait_r[k] != WAIT_W'(MAX_WAIT))) begin
          wait_r[k] <= wait_r[k] + WAIT_W'(1);
        end else begin
          wait_r[k] <= wait_r[k];
        end
      end
    end
  end
`else
  logic cfg_unused_s;
  assign cfg_unused_s = (MAX_WAIT < (1 << WAIT_W));
  assign winner_s     = highest_onehot(req);
`endif

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      grant_r <= 6'b000000;
      sel_r   <= 5'b00000;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      grant_r <= grant_nxt_s;
      sel_r   <= sel_nxt_s;
      valid_r <= valid_nxt_s;
    end
  end

  // Next-state logic; sel is the grant vector without its bit 0.
  always_comb begin
    state_nxt_s = state_r;
    grant_nxt_s = grant_r;
    sel_nxt_s   = sel_r;
    valid_nxt_s = valid_r;
    case (state_r)
      IDLE: begin
        if (|req) begin
          state_nxt_s = GRANT;
          grant_nxt_s = winner_s;
          sel_nxt_s   = winner_s[5:1];
          valid_nxt_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
          grant_nxt_s = 6'b000000;
          sel_nxt_s   = 5'b00000;
          valid_nxt_s = 1'b0;
        end
      end
      GRANT: begin
        if (handshake_s) begin
          state_nxt_s = IDLE;
          grant_nxt_s = 6'b000000;
          sel_nxt_s   = 5'b00000;
          valid_nxt_s = 1'b0;
        end else begin
          state_nxt_s = GRANT;
          grant_nxt_s = grant_r;
          sel_nxt_s   = sel_r;
          valid_nxt_s = valid_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        grant_nxt_s = 6'b000000;
        sel_nxt_s   = 5'b00000;
        valid_nxt_s = 1'b0;
      end
    endcase
  end

  assign sel   = sel_r;
  assign grant = grant_r;
  assign valid = valid_r;
  assign ack   = grant_r & {6{handshake_s}};

endmodule

// File: tb/tb_priority_sel_arbiter.sv
// Bench for priority_sel_arbiter: vector table, directed corner sequences and a
// random run against an index-based model (aging included when AGING_EN is defined).
module tb_priority_sel_arbiter;

  localparam int MAX_WAIT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] req;
  logic       out_ready;
  logic [4:0] sel;
  logic [5:0] grant;
  logic       valid;
  logic [5:0] ack;

  int n_checks = 0;
  int n_fail   = 0;

  // observed values from the latest step
  logic [5:0] a_ack, a_grant;
  logic [4:0] a_sel;
  logic       a_valid;

  // reference model: busy flag, winner index, wait counts
  bit  m_busy;
  int  m_win;
  int  m_cnt [6];
  logic [5:0] m_ack;

  priority_sel_arbiter #(.WAIT_W(4), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .req(req), .out_ready(out_ready),
    .sel(sel), .grant(grant), .valid(valid), .ack(ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] r;
    logic       o;
    logic [5:0] e_ack;
    logic [4:0] e_sel;
    logic [5:0] e_grant;
    logic       e_valid;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0;
    m_win  = 0;
    for (int k = 0; k < 6; k++) m_cnt[k] = 0;
  endtask

  function automatic int model_pick(input logic [5:0] r);
    int w;
    w = -1;
`ifdef AGING_EN
    for (int k = 4; k >= 0; k--) begin
      if (w < 0 && r[k] && m_cnt[k] == MAX_WAIT) w = k;
    end
`endif
    for (int k = 5; k >= 0; k--) begin
      if (w < 0 && r[k]) w = k;
    end
    return w;
  endfunction

  task automatic model_edge(input logic [5:0] r, input logic o);
    if (m_busy) begin
      if (o) begin
        for (int k = 0; k < 5; k++) begin
          if (k == m_win) m_cnt[k] = 0;
          else if (r[k] && m_cnt[k] < MAX_WAIT) m_cnt[k] = m_cnt[k] + 1;
        end
        m_busy = 0;
      end
    end else if (r != 6'd0) begin
      m_win  = model_pick(r);
      m_busy = 1;
    end
  endtask

  function automatic logic [5:0] m_grant();
    return m_busy ? (6'd1 << m_win) : 6'd0;
  endfunction

  function automatic logic [4:0] m_sel();
    return (m_busy && m_win > 0) ? (5'd1 << (m_win - 1)) : 5'd0;
  endfunction

  // One clock: drive, sample ack before the edge, sample registers after it.
  task automatic step(input logic [5:0] r, input logic o);
    req = r;
    out_ready = o;
    #1;
    a_ack = ack;
    m_ack = (m_busy && o) ? (6'd1 << m_win) : 6'd0;
    @(posedge clk);
    model_edge(r, o);
    #1;
    a_sel   = sel;
    a_grant = grant;
    a_valid = valid;
  endtask

  initial begin
    vecs[0]  = '{6'b000100, 1'b1, 6'b000000, 5'b00010, 6'b000100, 1'b1};
    vecs[1]  = '{6'b000100, 1'b1, 6'b000100, 5'b00000, 6'b000000, 1'b0};
    vecs[2]  = '{6'b100001, 1'b0, 6'b000000, 5'b10000, 6'b100000, 1'b1};
    vecs[3]  = '{6'b100001, 1'b1, 6'b100000, 5'b00000, 6'b000000, 1'b0};
    vecs[4]  = '{6'b000001, 1'b1, 6'b000000, 5'b00000, 6'b000001, 1'b1};
    vecs[5]  = '{6'b000000, 1'b1, 6'b000001, 5'b00000, 6'b000000, 1'b0};
    vecs[6]  = '{6'b000000, 1'b1, 6'b000000, 5'b00000, 6'b000000, 1'b0};
    vecs[7]  = '{6'b000010, 1'b0, 6'b000000, 5'b00001, 6'b000010, 1'b1};
    vecs[8]  = '{6'b100000, 1'b0, 6'b000000, 5'b00001, 6'b000010, 1'b1};
    vecs[9]  = '{6'b100000, 1'b1, 6'b000010, 5'b00000, 6'b000000, 1'b0};
    vecs[10] = '{6'b100000, 1'b1, 6'b000000, 5'b10000, 6'b100000, 1'b1};
    vecs[11] = '{6'b000000, 1'b1, 6'b100000, 5'b00000, 6'b000000, 1'b0};

    rst = 1'b1;
    req = 6'h3F;
    out_ready = 1'b1;
    model_reset();

    // reset holds everything at zero regardless of inputs
    repeat (3) begin
      @(negedge clk);
      check("rst_sel", sel, 5'd0);
      check("rst_grant", grant, 6'd0);
      check("rst_valid", valid, 1'b0);
      check("rst_ack", ack, 6'd0);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    req = 6'd0;

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].o);
      check($sformatf("vec%0d_ack", i), a_ack, vecs[i].e_ack);
      check($sformatf("vec%0d_sel", i), a_sel, vecs[i].e_sel);
      check($sformatf("vec%0d_grant", i), a_grant, vecs[i].e_grant);
      check($sformatf("vec%0d_valid", i), a_valid, vecs[i].e_valid);
    end

    // back-pressure on src2, src5 rises mid-hold
    step(6'b000100, 1'b0);
    check("bp_grant0", a_grant, 6'b000100);
    for (int c = 0; c < 10; c++) begin
      step((c >= 4) ? 6'b100100 : 6'b000100, 1'b0);
      check("bp_ack", a_ack, 6'd0);
      check("bp_sel", a_sel, 5'b00010);
      check("bp_grant", a_grant, 6'b000100);
      check("bp_valid", a_valid, 1'b1);
    end
    step(6'b100100, 1'b1);
    check("bp_ack_src2", a_ack, 6'b000100);
    check("bp_bubble", a_valid, 1'b0);
    step(6'b100100, 1'b0);
    check("bp_src5_grant", a_grant, 6'b100000);
    check("bp_src5_sel", a_sel, 5'b10000);
    step(6'b000000, 1'b1);
    check("bp_src5_ack", a_ack, 6'b100000);

    // asynchronous reset in the middle of a grant
    step(6'b001000, 1'b0);
    check("ar_grant_pre", a_grant, 6'b001000);
    #3;
    rst = 1'b1;
    out_ready = 1'b1;
    #1;
    check("ar_valid", valid, 1'b0);
    check("ar_grant", grant, 6'd0);
    check("ar_sel", sel, 5'd0);
    check("ar_ack", ack, 6'd0);
    model_reset();
    @(posedge clk);
    #2;
    check("ar_ack_hold", ack, 6'd0);
    rst = 1'b0;
    step(6'b001000, 1'b1);
    check("ar_regrant_ack", a_ack, 6'd0);
    check("ar_regrant", a_grant, 6'b001000);
    check("ar_regrant_sel", a_sel, 5'b00100);
    check("ar_regrant_valid", a_valid, 1'b1);
    step(6'b000000, 1'b1);
    check("ar_regrant_done", a_ack, 6'b001000);

`ifdef AGING_EN
    // src0 is promoted after losing MAX_WAIT times to src5
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int g = 0; g <= MAX_WAIT; g++) begin
        step(6'b100001, 1'b0);
        check("age_grant", a_grant, (g == MAX_WAIT) ? 6'b000001 : 6'b100000);
        check("age_sel", a_sel, (g == MAX_WAIT) ? 5'b00000 : 5'b10000);
        step(6'b100001, 1'b1);
        check("age_ack", a_ack, (g == MAX_WAIT) ? 6'b000001 : 6'b100000);
      end
    end
`endif

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [5:0] r;
      logic       o;
      r = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) r = 6'd0;
      o = ($urandom_range(0, 2) != 0);
      step(r, o);
      check("rnd_ack", a_ack, m_ack);
      check("rnd_sel", a_sel, m_sel());
      check("rnd_grant", a_grant, m_grant());
      check("rnd_valid", a_valid, m_busy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
